uart_apb_initiator: RTL and testbench
=====================================

// Module: uart_apb_initiator
// PURPOSE
//   APB3/APB4 requester that turns single-beat commands into APB transfers toward APB peripherals such as the UART16550 APB port.
//   Used by on-chip masters (debug/boot loaders) to reach peripherals without a full bus fabric.
//   One outstanding transfer at a time, with a bounded wait on pready.
// PARAMETERS
//   ADDR_W   32   APB address width
//   DATA_W   32   APB data width; STRB width = DATA_W/8
//   TIMEOUT  256  max ACCESS cycles waiting for pready; 0 = wait forever
// PORTS
//   clk            in   1         sole clock, all logic rising-edge
//   reset          in   1         asynchronous, active-high reset
//   req_valid      in   1         command valid
//   req_ready      out  1         command accepted when req_valid & req_ready
//   req_addr       in   ADDR_W    target address
//   req_write      in   1         1 = write, 0 = read
//   req_wdata      in   DATA_W    write data
//   req_strb       in   DATA_W/8  write byte strobes
//   req_prot       in   3         pprot value for this transfer
//   resp_valid     out  1         response valid
//   resp_ready     in   1         response consumed when resp_valid & resp_ready
//   resp_rdata     out  DATA_W    read data (0 for writes and timeouts)
//   resp_err       out  1         pslverr seen, or timeout
//   resp_timeout   out  1         transfer aborted by TIMEOUT
//   out_psel       out  1         APB select
//   out_penable    out  1         APB enable
//   out_pprot      out  3         APB protection
//   out_paddr      out  ADDR_W    APB address
//   out_pwrite     out  1         APB direction
//   out_pwdata     out  DATA_W    APB write data
//   out_pstrb      out  DATA_W/8  APB strobes (0 on reads)
//   out_pready     in   1         APB ready from responder
//   out_prdata     in   DATA_W    APB read data
//   out_pslverr    in   1         APB error, valid only with pready
// BEHAVIOUR
//   Reset: state IDLE; req_ready=1; resp_valid/resp_err/resp_timeout=0; resp_rdata=0.
//     Also: psel=penable=0; paddr/pwdata/pstrb/pprot/pwrite=0.
//   All outputs registered except req_ready = (state==IDLE).
//   FSM IDLE->SETUP->ACCESS->RESP->IDLE:
//     IDLE:   on req_valid, latch all req_* fields; next SETUP.
//     SETUP:  one cycle, psel=1, penable=0, APB outputs from latched command. pready ignored; next ACCESS.
//     ACCESS: psel=1, penable=1; APB outputs held stable.
//             pready=1 -> capture prdata (reads; writes give 0) and pslverr into resp_err; next RESP.
//             Else the wait counter increments. At counter==TIMEOUT (TIMEOUT!=0), abort: resp_err=1, resp_timeout=1, rdata=0; next RESP.
//     RESP:   psel=penable=0; resp_valid=1; response fields held until resp_ready; then IDLE.
//   Latency with zero-wait responder:
//     accept edge in cycle 0; SETUP in cycle 1; ACCESS in cycle 2; resp_valid in cycle 3.
//     Each pready wait cycle adds 1.
//   Earliest next accept is the cycle after the resp handshake. No back-to-back SETUP.
//   Wait counter clears on entry to ACCESS. Width = clog2(TIMEOUT+1); no wrap.
//   out_pstrb is forced to 0 when req_write=0 (APB4 rule), regardless of req_strb.
//   Address, data and strobes are passed unmodified; no alignment checks or byte-lane steering.
//   Idle APB outputs (paddr, pwdata, pwrite, pprot) hold their last values; psel stays 0.
//   Reset mid-transfer clears psel/penable at once. The pending command and response are dropped.
// TESTING
//   Write to 0x10000003, wdata 0x83000000, strb 0x8, pready=1:
//     psel=1 in cycles 1-2, penable=1 in cycle 2 only; resp_valid in cycle 3; resp_err=0.
//   Read with pready low for 3 ACCESS cycles, then prdata=0x60606060:
//     resp_rdata=0x60606060 and resp_valid in cycle 6; paddr stable throughout.
//   Read with pslverr=1 on the pready cycle:
//     resp_err=1, resp_timeout=0, resp_rdata=the sampled prdata.
//   TIMEOUT=8, pready held 0:
//     after 8 ACCESS cycles psel drops; resp_err=1, resp_timeout=1, resp_rdata=0.
//   resp_ready low for 5 cycles with req_valid high:
//     resp fields held; req_ready=0; no new psel until the cycle after the handshake.
//   reset pulsed during ACCESS:
//     psel/penable fall with no clock edge; resp_valid=0; req_ready=1 after reset release.

Source files
------------

// File: rtl/uart_apb_initiator.sv
// uart_apb_initiator: single-outstanding APB3/APB4 requester with a bounded pready wait.
module uart_apb_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_write,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [2:0]          req_prot,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                resp_timeout,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic timed_out;
  // cnt counts completed wait cycles, so this fires on the TIMEOUT-th unanswered ACCESS cycle
  assign timed_out = TIMEOUT != 0 && 32'(cnt) + 32'd1 == 32'(TIMEOUT);
  assign req_ready = state == IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
      out_psel     <= 1'b0;
      out_penable  <= 1'b0;
      out_pprot    <= '0;
      out_paddr    <= '0;
      out_pwrite   <= 1'b0;
      out_pwdata   <= '0;
      out_pstrb    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          out_paddr  <= req_addr;
          out_pwrite <= req_write;
          out_pwdata <= req_wdata;
          out_pstrb  <= req_write ? req_strb : '0;
          out_pprot  <= req_prot;
          out_psel   <= 1'b1;
          state      <= SETUP;
        end
        SETUP: begin
          out_penable <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: if (out_pready || timed_out) begin
          out_psel     <= 1'b0;
          out_penable  <= 1'b0;
          resp_valid   <= 1'b1;
          resp_rdata   <= out_pready && !out_pwrite ? out_prdata : '0;
          resp_err     <= out_pready ? out_pslverr : 1'b1;
          resp_timeout <= !out_pready;
          state        <= RESP;
        end else begin
          cnt <= &cnt ? cnt : cnt + 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_apb_initiator.sv
// tb_uart_apb_initiator: cycle-indexed transaction model plus directed literal checks.
module tb_uart_apb_initiator;
  localparam int TO = 8;
  localparam int INF = 32'h7fffffff;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_write = 0, resp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_strb = 0;
  logic [2:0] req_prot = 0;
  logic req_ready, resp_valid, resp_err, resp_timeout;
  logic [31:0] resp_rdata;
  logic out_psel, out_penable, out_pwrite;
  logic [2:0] out_pprot;
  logic [31:0] out_paddr, out_pwdata;
  logic [3:0] out_pstrb;
  logic out_pready = 1, out_pslverr = 0;
  logic [31:0] out_prdata = 0;
  int checks = 0, errors = 0, cyc = 0;

  uart_apb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_paddr(out_paddr), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: a transfer is described by its accept cycle and the cycle its response appears.
  logic busy = 0, m_write = 0, e_err = 0, e_to = 0;
  int acc = 0, rsp = INF;
  logic [31:0] m_addr = 0, m_wdata = 0, e_rdata = 0;
  logic [3:0] m_strb = 0;
  logic [2:0] m_prot = 0;

  always @(negedge clk) begin
    if (reset) begin
      busy = 0; m_addr = 0; m_wdata = 0; m_strb = 0; m_prot = 0; m_write = 0; rsp = INF;
    end else begin
      chk("req_ready", req_ready, !busy);
      chk("psel", out_psel, busy && cyc < rsp);
      chk("penable", out_penable, busy && cyc >= acc + 2 && cyc < rsp);
      chk("resp_valid", resp_valid, busy && cyc >= rsp);
      chk("paddr", out_paddr, m_addr);
      chk("pwdata", out_pwdata, m_wdata);
      chk("pwrite", out_pwrite, m_write);
      chk("pprot", out_pprot, m_prot);
      chk("pstrb", out_pstrb, m_strb);
      if (busy && cyc >= rsp) begin
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_err", resp_err, e_err);
        chk("resp_timeout", resp_timeout, e_to);
      end
      if (!busy) begin
        if (req_valid) begin
          busy = 1; acc = cyc; rsp = INF;
          m_addr = req_addr; m_wdata = req_wdata; m_write = req_write; m_prot = req_prot;
          m_strb = req_write ? req_strb : 4'h0;
        end
      end else if (rsp == INF) begin
        if (cyc >= acc + 2 && out_pready) begin
          rsp = cyc + 1; e_rdata = m_write ? 0 : out_prdata; e_err = out_pslverr; e_to = 0;
        end else if (cyc - (acc + 2) + 1 == TO) begin
          rsp = cyc + 1; e_rdata = 0; e_err = 1; e_to = 1;
        end
      end else if (cyc >= rsp && resp_ready) busy = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    req_valid = 1; req_addr = a; req_write = w; req_wdata = d; req_strb = s; req_prot = p;
  endtask

  initial begin
    step(); step();
    reset = 0;
    step();
    chk("rst req_ready", req_ready, 1);
    chk("rst psel", out_psel, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst paddr", out_paddr, 0);

    // zero-wait write
    issue(32'h10000003, 1, 32'h83000000, 4'h8, 3'd0);
    step(); req_valid = 0;
    chk("wr c1 psel", out_psel, 1);
    chk("wr c1 penable", out_penable, 0);
    step();
    chk("wr c2 penable", out_penable, 1);
    chk("wr c2 pstrb", out_pstrb, 4'h8);
    chk("wr c2 pwdata", out_pwdata, 32'h83000000);
    step();
    chk("wr c3 resp_valid", resp_valid, 1);
    chk("wr c3 psel", out_psel, 0);
    chk("wr c3 resp_err", resp_err, 0);
    step();

    // read with three wait cycles
    issue(32'h10000005, 0, 32'h0, 4'hF, 3'd3);
    out_pready = 0;
    step(); req_valid = 0;
    step();
    chk("rd pstrb", out_pstrb, 0);
    step(); step(); step();
    chk("rd c5 resp_valid", resp_valid, 0);
    out_pready = 1; out_prdata = 32'h60606060;
    step();
    chk("rd c6 resp_valid", resp_valid, 1);
    chk("rd c6 rdata", resp_rdata, 32'h60606060);
    chk("rd c6 paddr", out_paddr, 32'h10000005);
    step();

    // slave error on read
    issue(32'h10000001, 0, 32'h0, 4'h0, 3'd1);
    out_pslverr = 1; out_prdata = 32'hDEADBEEF;
    step(); req_valid = 0;
    step(); step();
    chk("err resp_err", resp_err, 1);
    chk("err resp_timeout", resp_timeout, 0);
    chk("err rdata", resp_rdata, 32'hDEADBEEF);
    out_pslverr = 0;
    step();

    // timeout with pready held low
    issue(32'h10000002, 0, 32'h0, 4'h0, 3'd0);
    out_pready = 0;
    step(); req_valid = 0;
    repeat (8) step();
    chk("to c9 psel", out_psel, 1);
    step();
    chk("to c10 psel", out_psel, 0);
    chk("to resp_err", resp_err, 1);
    chk("to resp_timeout", resp_timeout, 1);
    chk("to rdata", resp_rdata, 0);
    out_pready = 1;
    step();

    // response backpressure with req_valid held
    resp_ready = 0;
    issue(32'h00000020, 1, 32'h11223344, 4'h3, 3'd2);
    step(); step(); step();
    step();
    issue(32'h00000024, 1, 32'h55667788, 4'hC, 3'd2);
    step();
    chk("bp req_ready", req_ready, 0);
    chk("bp resp_valid", resp_valid, 1);
    chk("bp psel", out_psel, 0);
    step(); step(); step();
    resp_ready = 1;
    step();
    chk("bp c9 psel", out_psel, 0);
    chk("bp c9 req_ready", req_ready, 1);
    step(); req_valid = 0;
    chk("bp c10 psel", out_psel, 1);
    chk("bp c10 paddr", out_paddr, 32'h24);
    repeat (4) step();

    // asynchronous reset during ACCESS
    issue(32'h10000004, 0, 32'h0, 4'h0, 3'd0);
    out_pready = 0;
    step(); req_valid = 0;
    step();
    chk("ar pre penable", out_penable, 1);
    #1 reset = 1;
    #1;
    chk("ar psel", out_psel, 0);
    chk("ar penable", out_penable, 0);
    chk("ar resp_valid", resp_valid, 0);
    step(); reset = 0; out_pready = 1;
    step();
    chk("ar req_ready", req_ready, 1);

    // mixed transfers with varying wait counts
    for (int i = 0; i < 4; i++) begin
      int n;
      issue(32'h100 + 32'(i) * 4, i[0], 32'hA5A50000 + 32'(i), 4'(i + 1), 3'(i));
      out_prdata = 32'hC0DE0000 + 32'(i);
      out_pready = 0;
      step(); req_valid = 0;
      repeat (i + 1) step();
      out_pready = 1;
      n = 0;
      while (!resp_valid && n < 20) begin step(); n++; end
      chk("mix resp_valid seen", resp_valid, 1);
      step();
    end

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
